// File: rtl/chan_mux_pkg.sv
// Shared types and helpers for the chan_mux_seq channel multiplexer.
package chan_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_mux_seq_if.sv
// Control/data bundle between a channel source and chan_mux_seq.
interface chan_mux_seq_if
  import chan_mux_pkg::*;
#(
  parameter int W = 2,
  parameter int N = 4
);
  localparam int CW = ch_width(N);

  logic           EN;
  logic           MODE;
  logic [CW-1:0]  S;
  logic [N-1:0]   MASK;
  logic [N*W-1:0] DIN;
  logic [W-1:0]   Y;
  logic [CW-1:0]  CH;
  logic           VALID;
  logic           WRAP;

  modport master (
    output EN, MODE, S, MASK, DIN,
    input  Y, CH, VALID, WRAP
  );

  modport slave (
    input  EN, MODE, S, MASK, DIN,
    output Y, CH, VALID, WRAP
  );
endinterface

// File: rtl/chan_next_sel.sv
// Circular priority search: first unmasked channel strictly after cur,
// falling back to the lowest unmasked channel (a wrap, possibly onto cur).
module chan_next_sel
  import chan_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = ch_width(N)
) (
  input  logic [CW-1:0] cur,
  input  logic [N-1:0]  mask,
  output logic [CW-1:0] nxt,
  output logic          found,
  output logic          wrap
);

  logic          hit_hi;
  logic          hit_lo;
  logic [CW-1:0] idx_hi;
  logic [CW-1:0] idx_lo;

  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i] && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = CW'(i);
      end
      if (mask[i] && (CW'(i) > cur) && !hit_hi) begin
        hit_hi = 1'b1;
        idx_hi = CW'(i);
      end
    end
    found = hit_lo;
    wrap  = !hit_hi;
    nxt   = hit_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/chan_mux_seq.sv
// Registered N-channel W-bit multiplexer with manual select and masked
// auto-scan dwelling DWELL cycles per channel; WRAP marks a scan restart.
module chan_mux_seq
  import chan_mux_pkg::*;
#(
  parameter int W     = 2,
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic           CLK,
  input  logic           RST,
  chan_mux_seq_if.slave  bus
);

  localparam int CW   = ch_width(N);
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [W-1:0]    din_ch [N];
  mode_e           mode;

  logic [CW-1:0]   ch_q,    ch_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic            pend_q,  pend_d;
  logic [W-1:0]    y_q,     y_d;
  logic [CW-1:0]   chout_q, chout_d;
  logic            valid_q, valid_d;
  logic            wrap_q,  wrap_d;

  logic            s_hit;
  logic [W-1:0]    s_data;
  logic            cur_hit;
  logic            cur_mask;
  logic [W-1:0]    cur_data;

  logic [CW-1:0]   nxt_idx;
  logic            any_mask;
  logic            nxt_wraps;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_unpack
      assign din_ch[g] = bus.DIN[g*W +: W];
    end
  endgenerate

  assign mode = mode_e'(bus.MODE);

  // Index decode by compare so out-of-range selects (N not a power of two) read as empty.
  always_comb begin
    s_hit    = 1'b0;
    s_data   = '0;
    cur_hit  = 1'b0;
    cur_mask = 1'b0;
    cur_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.S == CW'(i)) begin
        s_hit  = 1'b1;
        s_data = din_ch[i];
      end
      if (ch_q == CW'(i)) begin
        cur_hit  = 1'b1;
        cur_mask = bus.MASK[i];
        cur_data = din_ch[i];
      end
    end
  end

  chan_next_sel #(
    .N  (N),
    .CW (CW)
  ) u_next_sel (
    .cur   (ch_q),
    .mask  (bus.MASK),
    .nxt   (nxt_idx),
    .found (any_mask),
    .wrap  (nxt_wraps)
  );

  // A wrap is decided on the edge ch_q advances but reported one edge later,
  // so WRAP lines up with the first Y cycle of the new channel.
  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    y_d     = '0;
    chout_d = chout_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (bus.EN) begin
      if (mode == MODE_MANUAL) begin
        y_d     = s_hit ? s_data : '0;
        valid_d = s_hit;
        chout_d = bus.S;
        ch_d    = bus.S;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end else begin
        chout_d = ch_q;
        pend_d  = 1'b0;
        if (any_mask) begin
          y_d     = cur_hit ? cur_data : '0;
          valid_d = cur_mask;
          wrap_d  = pend_q;
          if (!cur_mask || (cnt_q == CNT_LAST)) begin
            ch_d   = nxt_idx;
            cnt_d  = '0;
            pend_d = nxt_wraps;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ch_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      y_q     <= '0;
      chout_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      chout_q <= chout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.CH    = chout_q;
  assign bus.VALID = valid_q;
  assign bus.WRAP  = wrap_q;

endmodule

// File: doc/chan_mux_seq.md
# chan_mux_seq

Registered, parametrised N-channel, W-bit multiplexer with enable, manual select and an auto-scan mode that dwells a programmable number of cycles on each unmasked channel. Generalises the 4:1 2-bit enabled selector into a clocked datapath block feeding downstream capture/display logic. It reports which channel is on the output and pulses at each scan wrap.

## Interface
- W, 2: channel data width
- N, 4: channel count, ≥2
- DWELL, 4: cycles spent per channel in auto mode, ≥1
- CW, $clog2(N): select/channel index width (derived, not overridden)

- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- EN  in  1  enable; 0 forces output idle and freezes scan state
- MODE  in  1  0 = manual (S selects), 1 = auto scan
- S  in  CW  manual channel select
- MASK  in  N  auto-scan channel enable, bit i = channel i
- DIN  in  N*W  packed channel data, channel i = DIN[i*W +: W]
- Y  out  W  selected data, registered
- CH  out  CW  channel index that produced Y
- VALID  out  1  Y carries live channel data
- WRAP  out  1  one-cycle pulse: auto scan wrapped

## Operation
- Reset (async, any time, including mid-dwell): Y=0, CH=0, VALID=0, WRAP=0, internal ch_q=0, dwell count cnt=0.
- EN=0: next edge Y=0, VALID=0, WRAP=0, CH holds; ch_q and cnt hold.
- Manual (EN=1, MODE=0): Y←DIN[S], CH←S, VALID←1. S ≥ N (N not a power of two): Y←0, VALID←0, CH←S. MASK ignored; ch_q←S, cnt←0.
- Auto (EN=1, MODE=1): Y←DIN[ch_q], CH←ch_q, VALID←MASK[ch_q].
  - cnt increments each enabled auto cycle; at cnt==DWELL-1: cnt←0, ch_q←next unmasked index after ch_q, circular search.
  - ch_q currently masked: advance on the next edge regardless of cnt; cnt←0.
  - MASK all zero: ch_q, cnt hold; VALID=0, Y=0.
  - Single unmasked channel equal to ch_q: ch_q unchanged, cnt←0, WRAP asserted (wrap to self).
  - WRAP←1 on the edge where ch_q advances to index ≤ its old value; else 0.
- Mode switch manual→auto: scan continues from last ch_q (= last S), cnt=0. Auto→manual: next edge follows S.

## Timing
- Latency 1 cycle: DIN/S sampled at edge t appear on Y/CH after edge t.
- Y, CH, VALID, WRAP change only on CLK edges or asynchronous RST.
- Auto: with MASK all ones, each channel is on Y for exactly DWELL consecutive cycles; full scan period N*DWELL cycles.
- WRAP is coincident with the first Y cycle of the new channel's dwell.
- MASK/S changes take effect at the next edge; no glitch on outputs.
- No combinational input→output path.

## Structure
- Shared package chan_mux_pkg: MODE_MANUAL=1'b0, MODE_AUTO=1'b1 constants; channel-index width function.
- Sub-module chan_next_sel: combinational circular priority search, inputs current index + MASK, outputs next index, found flag, wrap flag.
- Top holds ch_q, cnt, output registers; DIN unpacked by generate loop.

## Test plan
(W=2, N=4, DWELL=2 unless stated)
- Reset mid-auto scan at ch_q=2: RST pulsed between edges -> Y=0, CH=0, VALID=0 immediately, scan restarts at channel 0 after release.
- EN=0, MODE=0, S=0, DIN={11,10,01,11} -> Y=00, VALID=0; then EN=1, S=0..3 stepping -> Y follows 11,01,10,11 one cycle later, CH=S delayed.
- Auto, MASK=1111, DIN={D=01,C=11,B=10,A=00} -> CH sequence 0,0,1,1,2,2,3,3,0; WRAP high only on the cycle CH returns to 0.
- Auto, MASK=1010 -> CH 1,1,3,3,1,…; WRAP on each 3→1; clear MASK[3] while CH=3 -> advance to 1 at next edge.
- MASK=0000 in auto -> Y=0, VALID=0, CH frozen; restore MASK=0100 -> CH=2 continuous, WRAP every DWELL cycles.
- N=3 build, manual S=3 -> Y=0, VALID=0; S=2 -> Y=DIN[2], VALID=1.
